// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared FSM encoding and descriptor geometry for the DMA scheduler
package dma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int DESC_AW     = 32;
    localparam int DESC_FIELDS = 3;

endpackage

// File: rtl/dma_sched_if.sv
// dma_sched_if: host descriptor port, DMA engine port and scheduler status bundle
interface dma_sched_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          sched_en;
    logic          flush;
    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_src;
    logic [AW-1:0] desc_dest;
    logic [AW-1:0] desc_len;
    logic          dma_start;
    logic [AW-1:0] dma_src;
    logic [AW-1:0] dma_dest;
    logic [AW-1:0] dma_len;
    logic          dma_busy;
    logic          dma_done;
    logic          cmpl;
    logic [15:0]   cmpl_cnt;
    logic [LW-1:0] level;
    logic          sched_busy;

    modport master (
        output sched_en, flush, desc_valid, desc_src, desc_dest, desc_len, dma_busy, dma_done,
        input  desc_ready, dma_start, dma_src, dma_dest, dma_len, cmpl, cmpl_cnt, level, sched_busy
    );

    modport slave (
        input  sched_en, flush, desc_valid, desc_src, desc_dest, desc_len, dma_busy, dma_done,
        output desc_ready, dma_start, dma_src, dma_dest, dma_len, cmpl, cmpl_cnt, level, sched_busy
    );

endinterface

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: circular descriptor queue with flush and occupancy count
module dma_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = r_level == LW'(DEPTH);
    assign o_empty   = r_level == '0;
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers and occupancy; a flush empties the queue and drops any same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    // Descriptor storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/dma_sched.sv
// dma_sched: launches queued DMA descriptors one at a time and counts completions
module dma_sched
    import dma_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DESC_AW
) (
    input logic        clk,
    input logic        rst,
    dma_sched_if.slave bus
);
    localparam int W  = DESC_FIELDS * AW;
    localparam int LW = $clog2(DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_zero;
    logic          w_retire;
    logic [W-1:0]  w_head;
    logic [LW-1:0] w_level;
    logic          r_dma_start;
    logic          r_cmpl;
    logic [15:0]   r_cmpl_cnt;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dest;
    logic [AW-1:0] r_len;

    assign w_push   = bus.desc_valid && !w_full;
    assign w_zero   = w_head[AW-1:0] == '0;
    assign w_retire = (w_pop && w_zero) || (r_state == WAIT && bus.dma_done);

    dma_desc_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_wdata ({bus.desc_src, bus.desc_dest, bus.desc_len}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Next state and pop decision; zero-length descriptors retire straight from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sched_en && !w_empty && !bus.flush) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_zero ? IDLE : LAUNCH;
                end
            end
            LAUNCH:  w_state_nxt = WAIT;
            WAIT:    w_state_nxt = bus.dma_done ? IDLE : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Registered outputs: start pulse aligned with LAUNCH, completion pulse and count, held transfer parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dma_start <= 1'b0;
            r_cmpl      <= 1'b0;
            r_cmpl_cnt  <= '0;
            r_src       <= '0;
            r_dest      <= '0;
            r_len       <= '0;
        end else begin
            r_dma_start <= w_pop && !w_zero;
            r_cmpl      <= w_retire;
            if (w_retire) r_cmpl_cnt <= r_cmpl_cnt + 16'd1;
            if (w_pop) {r_src, r_dest, r_len} <= w_head;
        end
    end

    assign bus.desc_ready = !w_full;
    assign bus.sched_busy = (r_state != IDLE) || (w_level != '0);
    assign bus.level      = w_level;
    assign bus.dma_start  = r_dma_start;
    assign bus.cmpl       = r_cmpl;
    assign bus.cmpl_cnt   = r_cmpl_cnt;
    assign bus.dma_src    = r_src;
    assign bus.dma_dest   = r_dest;
    assign bus.dma_len    = r_len;

endmodule
